// File: rtl/fp27_pkg.sv
// fp27_pkg: shared constants and helpers for the GMM 27-bit float format.
//   Word layout: [26] sign, [25:18] biased exponent (bias 127), [17:0] fraction.
//   Exponent 0 encodes zero (no denormals); exponent 255 is an ordinary
//   large value. Reused by the float adder, multiplier and converter blocks.
package fp27_pkg;

  localparam int FP_W      = 27;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 18;
  localparam int FP_BIAS   = 127;

  // Field bit positions
  localparam int FP_SIGN_BIT = 26;
  localparam int FP_EXP_MSB  = 25;
  localparam int FP_EXP_LSB  = 18;
  localparam int FP_FRAC_MSB = 17;
  localparam int FP_FRAC_LSB = 0;

  // Mantissa with the hidden one, and the signed shift-count width
  localparam int FP_MANT_W  = FP_FRAC_W + 1;
  localparam int FP_SHIFT_W = 10;

  typedef logic [FP_W-1:0] fp27_t;

  // Decoded stage-1 word of the float-to-fixed converter
  typedef struct packed {
    logic                         sign;
    logic                         zero;
    logic                         ovf;
    logic [FP_MANT_W-1:0]         mant;
    logic signed [FP_SHIFT_W-1:0] k;
  } fp27_dec_t;

  function automatic logic fp_sign(input fp27_t w);
    return w[FP_SIGN_BIT];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input fp27_t w);
    return w[FP_EXP_MSB:FP_EXP_LSB];
  endfunction

  function automatic logic [FP_FRAC_W-1:0] fp_frac(input fp27_t w);
    return w[FP_FRAC_MSB:FP_FRAC_LSB];
  endfunction

  // Zero test: a zero exponent means the value is zero regardless of fraction
  function automatic logic fp_exp_is_zero(input fp27_t w);
    return (w[FP_EXP_MSB:FP_EXP_LSB] == '0);
  endfunction

endpackage

// File: rtl/fp27_to_fixed_if.sv
// fp27_to_fixed_if: stream bundle around the float-to-fixed converter.
//   Input side : iValid, oReady, iFp
//   Output side: oValid, iReady, oData, oSat
// Handshake: a word moves on a side in any cycle where its valid and its
// ready are both 1 at the clock edge; a producer holding valid=1 keeps its
// payload stable until the transfer happens, and valid never depends on ready.
//   master: the environment (drives iValid/iFp/iReady)
//   slave : the converter
interface fp27_to_fixed_if #(parameter int OUT_W = 24);
  import fp27_pkg::*;

  logic             iValid;
  logic             oReady;
  fp27_t            iFp;
  logic             oValid;
  logic             iReady;
  logic [OUT_W-1:0] oData;
  logic             oSat;

  modport master (
    output iValid, iFp, iReady,
    input  oReady, oValid, oData, oSat
  );

  modport slave (
    input  iValid, iFp, iReady,
    output oReady, oValid, oData, oSat
  );
endinterface

// File: rtl/fp27_align_shift.sv
// fp27_align_shift: combinational barrel shifter aligning a float mantissa to
// the fixed-point grid.
//   m   : mantissa with hidden one (MW bits)
//   k   : signed shift count; k >= 0 shifts left, k < 0 shifts right
//   mag : OUT_W+1 bit magnitude; right shifts truncate toward zero
//   hi  : set when a left shift pushed set bits above the magnitude width
module fp27_align_shift #(
  parameter int OUT_W = 24,
  parameter int MW    = 19,
  parameter int KW    = 10
) (
  input  logic [MW-1:0]        m,
  input  logic signed [KW-1:0] k,
  output logic [OUT_W:0]       mag,
  output logic                 hi
);
  localparam int MAG_W  = OUT_W + 1;
  localparam int WIDE_W = MW + MAG_W;

  logic [KW-1:0]     k_u;
  logic [KW-1:0]     nk;
  logic [WIDE_W-1:0] wide;

  always_comb begin
    mag  = '0;
    hi   = 1'b0;
    wide = '0;
    k_u  = k;
    nk   = -k;
    if (!k[KW-1]) begin
      if (k_u >= KW'(MAG_W)) begin
        // Every mantissa bit lands above the magnitude
        hi = |m;
      end else begin
        wide = {{MAG_W{1'b0}}, m} << k_u;
        mag  = wide[MAG_W-1:0];
        hi   = |wide[WIDE_W-1:MAG_W];
      end
    end else begin
      if (nk < KW'(MW)) begin
        mag = MAG_W'(m >> nk);
      end
    end
  end
endmodule

// File: rtl/fp27_to_fixed.sv
// fp27_to_fixed: two-stage pipelined converter from the 27-bit GMM float to
// signed two's-complement fixed point with INT_W integer bits (sign included)
// and FRAC_W fraction bits. Out-of-range values clamp and raise oSat.
//   iCLK : clock
//   iRST : asynchronous reset, active-high
//   bus  : slave side of fp27_to_fixed_if (iValid/oReady/iFp in,
//          oValid/iReady/oData/oSat out); latency 2 when not stalled.
module fp27_to_fixed
  import fp27_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  fp27_to_fixed_if.slave   bus
);
  localparam int OUT_W = INT_W + FRAC_W;
  localparam int MAG_W = OUT_W + 1;

  localparam logic [MAG_W-1:0] POS_MAX = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};

  logic v1, v2;
  logic en1, en2;

  fp27_dec_t s1_d, s1_q;

  logic [OUT_W-1:0] data_d, data_q;
  logic             sat_d, sat_q;

  logic [MAG_W-1:0] mag;
  logic             mag_hi;

  int exp_unb;

  // Stage 2 frees up when empty or its result retires; stage 1 frees up when
  // empty or when it can move forward, so a full pipe still streams.
  assign en2 = ~v2 | bus.iReady;
  assign en1 = ~v1 | en2;

  assign bus.oReady = en1;
  assign bus.oValid = v2;
  assign bus.oData  = data_q;
  assign bus.oSat   = sat_q;

  // Stage 1 decode
  always_comb begin
    exp_unb   = int'(fp_exp(bus.iFp)) - FP_BIAS;
    s1_d.sign = fp_sign(bus.iFp);
    s1_d.zero = fp_exp_is_zero(bus.iFp);
    s1_d.mant = {1'b1, fp_frac(bus.iFp)};
    s1_d.k    = FP_SHIFT_W'(exp_unb + FRAC_W - FP_FRAC_W);
    s1_d.ovf  = (exp_unb >= INT_W - 1) & ~s1_d.zero;
  end

  fp27_align_shift #(
    .OUT_W (OUT_W),
    .MW    (FP_MANT_W),
    .KW    (FP_SHIFT_W)
  ) u_align (
    .m   (s1_q.mant),
    .k   (s1_q.k),
    .mag (mag),
    .hi  (mag_hi)
  );

  // Stage 2 clamp and sign application
  always_comb begin
    data_d = '0;
    sat_d  = 1'b0;
    if (s1_q.zero) begin
      data_d = '0;
      sat_d  = 1'b0;
    end else if (!s1_q.sign) begin
      if (s1_q.ovf || mag_hi || (mag > POS_MAX)) begin
        data_d = POS_MAX[OUT_W-1:0];
        sat_d  = 1'b1;
      end else begin
        data_d = mag[OUT_W-1:0];
      end
    end else begin
      // The most negative code is exactly representable, so it wins over the
      // coarse exponent overflow flag.
      if (!mag_hi && (mag == NEG_LIM)) begin
        data_d = NEG_LIM[OUT_W-1:0];
        sat_d  = 1'b0;
      end else if (s1_q.ovf || mag_hi || (mag > NEG_LIM)) begin
        data_d = NEG_LIM[OUT_W-1:0];
        sat_d  = 1'b1;
      end else begin
        // mag == 0 negates to 0, so no negative-zero pattern can appear
        data_d = -mag[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1     <= 1'b0;
      s1_q   <= '0;
    end else if (en1) begin
      v1     <= bus.iValid;
      s1_q   <= s1_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v2     <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_fp27_to_fixed.sv
module tb_fp27_to_fixed;
  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = INT_W + FRAC_W;
  localparam int RW     = OUT_W + 1;

  localparam logic [26:0] W_1P0 = 27'h1FC0000;
  localparam logic [26:0] W_2P0 = 27'h2000000;
  localparam logic [26:0] W_3P0 = 27'h2020000;

  logic clk;
  logic rst;

  fp27_to_fixed_if #(.OUT_W(OUT_W)) bus ();

  fp27_to_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int tests   = 0;
  int fails   = 0;
  int retired = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value * 2^FRAC_W = M * 2^(e - 127 + FRAC_W - 18), truncated
  // toward zero, then clamped to the signed OUT_W range.
  function automatic logic [RW-1:0] model(input logic [26:0] w);
    int         e;
    int         p;
    longint     m;
    longint     mag;
    longint     lim;
    logic [OUT_W-1:0] d;
    e   = int'(w[25:18]);
    lim = longint'(1) << (OUT_W - 1);
    if (e == 0) return '0;
    m = (longint'(1) << 18) + longint'(w[17:0]);
    p = e - 127 + FRAC_W - 18;
    if (p >= 40)       mag = longint'(1) << 60;
    else if (p >= 0)   mag = m << p;
    else if (-p >= 62) mag = 0;
    else               mag = m >> (-p);
    if (!w[26]) begin
      if (mag > lim - 1) return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      d = OUT_W'(mag);
      return {1'b0, d};
    end
    if (mag == lim) return {1'b0, 1'b1, {(OUT_W-1){1'b0}}};
    if (mag > lim)  return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    d = OUT_W'(-mag);
    return {1'b0, d};
  endfunction

  // Monitor: compare every result in the cycle it retires
  always @(negedge clk) begin
    if (!rst && bus.oValid && bus.iReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.oData), 32'hDEAD);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("result", 32'({bus.oSat, bus.oData}), 32'(e));
        retired++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [26:0] w, output int waits);
    bit done;
    done       = 1'b0;
    waits      = 0;
    bus.iValid = 1'b1;
    bus.iFp    = w;
    while (!done) begin
      @(negedge clk);
      if (bus.oReady) begin
        @(posedge clk);
        exp_q.push_back(model(w));
        #1;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          check("send_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    bus.iValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [26:0] rand_word();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 9);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else if (r == 2) e = 8'($urandom_range(140, 146));
    else             e = 8'($urandom_range(105, 150));
    return {1'($urandom_range(0, 1)), e, 18'($urandom_range(0, (1 << 18) - 1))};
  endfunction

  // ---------------- directed sequence ----------------
  int waits;
  int ret0;

  initial begin
    rst        = 1'b1;
    bus.iValid = 1'b0;
    bus.iFp    = '0;
    bus.iReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oValid", 32'(bus.oValid), 32'd0);
    check("rst_oData",  32'(bus.oData),  32'd0);
    check("rst_oSat",   32'(bus.oSat),   32'd0);
    check("rst_oReady", 32'(bus.oReady), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: result valid on the second edge counting the accept edge
    send(W_1P0, waits);
    @(negedge clk);
    check("latency_early", 32'(bus.oValid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(bus.oValid), 32'd1);
    @(posedge clk);
    #1;

    // Main function and range limits
    send(27'h6010000, waits);                       // -2.5
    send(27'(147) << 18, waits);                    // 2^20 saturates
    send((27'd1 << 26) | (27'(142) << 18), waits);  // -32768 exact
    send((27'd1 << 26) | (27'(143) << 18), waits);  // -65536 saturates
    send(27'(118) << 18, waits);                    // 2^-9 truncates to 0
    send(27'h4000000, waits);                       // e=0 with sign
    send(27'h7FFFFFF, waits);                       // e=255 negative
    send(27'h3FFFFFF, waits);                       // e=255 positive
    send((27'd1 << 26) | (27'(126) << 18) | 27'h3FFFF, waits); // -0.99.. -> trunc
    drain();

    // Backpressure: two accepted, third held
    bus.iReady = 1'b0;
    send(W_1P0, waits);
    check("bp_accept1", 32'(waits), 32'd0);
    send(W_2P0, waits);
    check("bp_accept2", 32'(waits), 32'd0);
    bus.iValid = 1'b1;
    bus.iFp    = W_3P0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_oReady_low", 32'(bus.oReady), 32'd0);
      check("bp_hold_data",  32'({bus.oValid, bus.oSat, bus.oData}), {7'd0, 1'b1, 1'b0, 24'h000100});
      @(posedge clk);
      #1;
    end
    bus.iReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_gap", 32'(bus.oValid), 32'd1);
      if (i == 0) check("bp_third_taken", 32'(bus.oReady), 32'd1);
      @(posedge clk);
      if (i == 0) exp_q.push_back(model(W_3P0));
      #1;
      bus.iValid = 1'b0;
    end
    drain();

    // Throughput: one accept per cycle and one retire per cycle
    ret0 = retired;
    for (int i = 0; i < 100; i++) begin
      send(rand_word(), waits);
      check("tp_accept", 32'(waits), 32'd0);
    end
    drain();
    check("tp_retired", 32'(retired - ret0), 32'd100);

    // Reset with two words in flight
    bus.iReady = 1'b0;
    send(W_2P0, waits);
    send(W_3P0, waits);
    #2;
    rst = 1'b1;
    #1;
    check("arst_oValid", 32'(bus.oValid), 32'd0);
    check("arst_oData",  32'(bus.oData),  32'd0);
    check("arst_oSat",   32'(bus.oSat),   32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.iReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_stale", 32'(bus.oValid), 32'd0);
      @(posedge clk);
      #1;
    end
    ret0 = retired;
    send(27'h6010000, waits);
    drain();
    check("arst_next_word", 32'(retired - ret0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp27_to_fixed.md
Name: fp27_to_fixed

Overview:
- Pipelined converter from the GMM's 27-bit floating-point word to a signed two's-complement fixed-point value.
- Sits at the output end of the GMM float datapath (after adders and multipliers). It hands mean, variance and weight results back to integer-domain logic: pixel compare, thresholding and memory write-back.
- Valid/ready on both sides; latency 2 cycles when not stalled.

Parameters:
- INT_W, 16, integer bits of the output including the sign bit
- FRAC_W, 8, fractional bits of the output; output width OUT_W = INT_W + FRAC_W

Ports:
- iCLK  input  1  clock
- iRST  input  1  asynchronous reset, active-high
- iValid  input  1  iFp holds a word to convert
- oReady  output  1  block accepts iFp this cycle
- iFp  input  27  float: [26] sign, [25:18] exponent (bias 127), [17:0] fraction
- oValid  output  1  oData/oSat hold a result
- iReady  input  1  downstream accepts the result this cycle
- oData  output  OUT_W  fixed-point result, two's complement
- oSat  output  1  result was clamped

Behaviour:
- Number format:
  - value = (-1)^s * 1.f * 2^(e-127), f = 18 bits.
  - e == 0 means zero; there are no denormals.
  - e == 255 is treated as a large finite value, so it saturates.
- Reset (async, iRST=1): both stage valid flags = 0, oValid = 0, oData = 0, oSat = 0. oReady = 1 after reset. Any in-flight data is discarded.
- Handshake:
  - Input transfer on iValid & oReady. Output transfer on oValid & iReady.
  - oData and oSat stay stable while oValid=1 and iReady=0.
- Pipeline control: en2 = ~v2 | iReady; en1 = ~v1 | en2; oReady = en1. Full throughput of 1 per cycle when iReady is held high. At most 2 words are in flight.
- Stage 1 (registered on en1):
  - latch sign; latch mantissa M = {1, f} (19 bits); latch zero flag (e == 0).
  - compute shift k = e - 127 + FRAC_W - 18 as a signed 10-bit value.
  - compute overflow flag ovf = (e - 127 >= INT_W - 1) & ~zero.
- Stage 2 (registered on en2; oValid = v2):
  - k >= 0: mag = M << k, computed in an OUT_W+1 bit magnitude.
  - k < 0: mag = M >> -k, truncating toward zero. -k >= 19 gives mag = 0.
  - zero flag set: oData = 0, oSat = 0.
  - positive input:
    - if ovf, or mag > 2^(OUT_W-1) - 1: oData = 2^(OUT_W-1) - 1 and oSat = 1.
    - otherwise oData = mag.
  - negative input:
    - mag == 2^(OUT_W-1) exactly: oData = -2^(OUT_W-1), oSat = 0.
    - mag above that, or ovf: oData = -2^(OUT_W-1), oSat = 1.
    - otherwise oData = -mag.
  - A negative value that truncates to mag = 0 gives oData = 0, never a negative zero pattern.
- Simultaneous events:
  - With the pipeline full and iReady=1, one word is accepted and one result retires in the same cycle, with no bubble.
  - iValid with oReady=0: the word is not taken. Upstream holds iFp.
- Ordering: results leave in acceptance order. No drop or duplicate under any iReady pattern.

Decomposition:
- Shared package fp27_pkg holds:
  - FP_W = 27, FP_EXP_W = 8, FP_FRAC_W = 18, FP_BIAS = 127
  - field bit positions for sign, exponent and fraction
  - zero-exponent test helper
- These constants are reused by FpAdd and the GMM multiplier blocks.
- Sub-module fp27_align_shift: a combinational barrel shifter taking M, signed k and OUT_W, returning mag plus a shifted-out-high flag. It is instantiated in stage 2.

Test Plan:
- Defaults (INT_W=16, FRAC_W=8), iReady=1.
  - iFp=0x1FC0000 (1.0) -> oData=0x000100, oSat=0, 2 cycles after acceptance.
  - iFp=0x6010000 (-2.5) -> oData=0xFFFD80, oSat=0.
- Range limits:
  - iFp=147<<18 (2^20) -> oData=0x7FFFFF, oSat=1.
  - iFp=(1<<26)|(142<<18) (-32768) -> oData=0x800000, oSat=0.
  - iFp=(1<<26)|(143<<18) (-65536) -> oData=0x800000, oSat=1.
- Underflow and zero:
  - iFp=118<<18 (2^-9) -> oData=0, oSat=0.
  - iFp=0x4000000 (e=0, sign=1) -> oData=0, oSat=0.
- Backpressure: iReady=0, offer 1.0, 2.0, 3.0 back-to-back.
  - oReady drops after 2 accepts and the third word is held.
  - Raise iReady -> outputs 0x000100, 0x000200, 0x000300 in order, no gaps.
- Throughput: 100 random words with iReady=1 -> one result per cycle. Every result matches the reference model, including truncation toward zero and the saturation rules.
- Reset mid-operation: assert iRST with 2 words in flight.
  - oValid=0 and oData=0 immediately (async).
  - After release, no stale result appears and the next word converts correctly.
